// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: branch kinds, ARM condition codes and
// the condition evaluator used for B.cond.
package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_CBZ   = 3'd2,
    BR_CBNZ  = 3'd3,
    BR_BCOND = 3'd4,
    BR_BL    = 3'd5,
    BR_BR    = 3'd6,
    BR_RET   = 3'd7
  } br_kind_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // NV behaves as "always" on this datapath, same as AL.
  function automatic logic cond_eval(input logic [3:0] cond, input logic n,
                                     input logic z, input logic c, input logic v);
    logic res;
    res = 1'b0;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c & !z;
      COND_LS: res = !c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z & (n == v);
      COND_LE: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry (the slot just past the top), keeping the count saturated.
// Pop on an empty stack is ignored. Top is readable combinationally so a
// RET can redirect in the same cycle.
module return_stack #(
  parameter int BITSIZE   = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [BITSIZE-1:0] push_data,
  output logic [BITSIZE-1:0] top,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   ptr_reg, ptr_next, wr_ptr;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [BITSIZE-1:0] entries [RAS_DEPTH];

  assign wr_ptr = ptr_reg + PTR_W'(1);

  // Pointer and occupancy update; pushes win, pops on empty do nothing.
  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    if (push) begin
      ptr_next = wr_ptr;
      if (count_reg != CNT_W'(RAS_DEPTH))
        count_next = count_reg + CNT_W'(1);
    end else if (pop && (count_reg != '0)) begin
      ptr_next   = ptr_reg - PTR_W'(1);
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer/count state; reset empties the stack without clearing entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
      logic [BITSIZE-1:0] entry_reg;
      // Each slot captures the pushed address when the write pointer hits it.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr == PTR_W'(gi)))
          entry_reg <= push_data;
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign top   = entries[ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(RAS_DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, resolves the branch kind into a
// taken decision and target in the same cycle, drives the BL link address
// and keeps a return-address stack for RET prediction.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                 BITSIZE     = 64,
  parameter logic [BITSIZE-1:0] RESET_PC    = '0,
  parameter int                 INSTR_BYTES = 4,
  parameter int                 RAS_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [2:0]         br_kind,
  input  logic [BITSIZE-1:0] br_offset,
  input  logic [BITSIZE-1:0] br_target,
  input  logic               flagz,
  input  logic               flagn,
  input  logic               flagc,
  input  logic               flagv,
  input  logic [3:0]         cond,
  output logic [BITSIZE-1:0] pc,
  output logic               taken,
  output logic               link_valid,
  output logic [BITSIZE-1:0] link_addr,
  output logic               ras_empty,
  output logic               ras_full
);

  br_kind_e           kind;
  logic               cond_true;
  logic [BITSIZE-1:0] pc_reg, pc_next;
  logic [BITSIZE-1:0] seq_pc, rel_target, target;
  logic               link_valid_reg, link_valid_next;
  logic [BITSIZE-1:0] link_addr_reg, link_addr_next;
  logic               ras_push, ras_pop;
  logic [BITSIZE-1:0] ras_top;

  assign kind       = br_kind_e'(br_kind);
  assign cond_true  = cond_eval(cond, flagn, flagz, flagc, flagv);
  assign seq_pc     = pc_reg + BITSIZE'(INSTR_BYTES);
  assign rel_target = pc_reg + br_offset;

  // Taken decision and target select for the instruction at pc.
  always_comb begin
    taken  = 1'b0;
    target = rel_target;
    case (kind)
      BR_B, BR_BL: taken = br_valid;
      BR_CBZ:      taken = br_valid & flagz;
      BR_CBNZ:     taken = br_valid & !flagz;
      BR_BCOND:    taken = br_valid & cond_true;
      BR_BR: begin
        taken  = br_valid;
        target = br_target;
      end
      BR_RET: begin
        taken  = br_valid;
        target = ras_empty ? br_target : ras_top;
      end
      default: taken = 1'b0;
    endcase
  end

  // Next-state for PC, link outputs and stack requests; stall freezes all.
  always_comb begin
    ras_push        = !stall && br_valid && (kind == BR_BL);
    ras_pop         = !stall && br_valid && (kind == BR_RET) && !ras_empty;
    pc_next         = pc_reg;
    link_valid_next = 1'b0;
    link_addr_next  = link_addr_reg;
    if (!stall) begin
      pc_next = taken ? target : seq_pc;
      if (ras_push) begin
        link_valid_next = 1'b1;
        link_addr_next  = seq_pc;
      end
    end
  end

  // PC and link registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      link_valid_reg <= 1'b0;
      link_addr_reg  <= '0;
    end else begin
      pc_reg         <= pc_next;
      link_valid_reg <= link_valid_next;
      link_addr_reg  <= link_addr_next;
    end
  end

  return_stack #(
    .BITSIZE  (BITSIZE),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(seq_pc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign pc         = pc_reg;
  assign link_valid = link_valid_reg;
  assign link_addr  = link_addr_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [2:0]  br_kind;
  logic [63:0] br_offset;
  logic [63:0] br_target;
  logic        flagz, flagn, flagc, flagv;
  logic [3:0]  cond;
  logic [63:0] pc;
  logic        taken;
  logic        link_valid;
  logic [63:0] link_addr;
  logic        ras_empty, ras_full;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(
    .BITSIZE    (64),
    .RESET_PC   (64'd0),
    .INSTR_BYTES(4),
    .RAS_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_kind   (br_kind),
    .br_offset (br_offset),
    .br_target (br_target),
    .flagz     (flagz),
    .flagn     (flagn),
    .flagc     (flagc),
    .flagv     (flagv),
    .cond      (cond),
    .pc        (pc),
    .taken     (taken),
    .link_valid(link_valid),
    .link_addr (link_addr),
    .ras_empty (ras_empty),
    .ras_full  (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] k, input logic [63:0] off,
                       input logic [63:0] tgt);
    br_valid  = v;
    br_kind   = k;
    br_offset = off;
    br_target = tgt;
  endtask

  logic [63:0] pc_exp;
  logic [63:0] links [5];
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    flagz = 0; flagn = 0; flagc = 0; flagv = 0; cond = 4'd0;
    tick(); tick();
    chk("reset_pc", pc, 64'd0);
    chk("reset_link_valid", {63'd0, link_valid}, 64'd0);
    chk("reset_link_addr", link_addr, 64'd0);
    chk("reset_ras_empty", {63'd0, ras_empty}, 64'd1);
    chk("reset_ras_full", {63'd0, ras_full}, 64'd0);
    rst = 1'b0;

    // Ten sequential cycles.
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("seq_pc", pc, 64'(4 * i));
    end
    chk("seq_ras_empty", {63'd0, ras_empty}, 64'd1);

    // B, CBZ (not taken), CBNZ (taken).
    drive(1'b1, 3'd1, 64'd24, 64'd0);
    #1 chk("b_taken", {63'd0, taken}, 64'd1);
    tick(); chk("b_pc", pc, 64'd64);
    drive(1'b1, 3'd2, 64'd24, 64'd0); flagz = 0;
    #1 chk("cbz_taken", {63'd0, taken}, 64'd0);
    tick(); chk("cbz_pc", pc, 64'd68);
    drive(1'b1, 3'd3, 64'd24, 64'd0);
    #1 chk("cbnz_taken", {63'd0, taken}, 64'd1);
    tick(); chk("cbnz_pc", pc, 64'd92);
    pc_exp = 64'd92;

    // BCOND sweep: set A is N=1 Z=0 C=1 V=0, set B is N=0 Z=1 C=0 V=1.
    // Bit c of each vector is the hand-derived outcome for condition c.
    exp_a = 16'b1110_1001_1001_0110;
    exp_b = 16'b1110_1010_0110_1001;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin flagn = 1; flagz = 0; flagc = 1; flagv = 0; end
      else        begin flagn = 0; flagz = 1; flagc = 0; flagv = 1; end
      for (int c = 0; c < 16; c++) begin
        logic t;
        t = (s == 0) ? exp_a[c] : exp_b[c];
        drive(1'b1, 3'd4, 64'd8, 64'd0);
        cond = 4'(c);
        #1 chk($sformatf("bcond_taken_s%0d_c%0d", s, c), {63'd0, taken}, {63'd0, t});
        tick();
        pc_exp = pc_exp + (t ? 64'd8 : 64'd4);
        chk($sformatf("bcond_pc_s%0d_c%0d", s, c), pc, pc_exp);
      end
    end
    flagn = 0; flagz = 0; flagc = 0; flagv = 0; cond = 4'd0;

    // Move to 0x100, then BL / RET.
    drive(1'b1, 3'd1, 64'h100 - pc_exp, 64'd0);
    tick(); chk("goto_100", pc, 64'h100);
    drive(1'b1, 3'd5, 64'h40, 64'd0);
    #1 chk("bl_taken", {63'd0, taken}, 64'd1);
    tick();
    chk("bl_pc", pc, 64'h140);
    chk("bl_link_valid", {63'd0, link_valid}, 64'd1);
    chk("bl_link_addr", link_addr, 64'h104);
    chk("bl_ras_empty", {63'd0, ras_empty}, 64'd0);
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    tick();
    chk("bl_link_drop", {63'd0, link_valid}, 64'd0);
    chk("bl_link_hold", link_addr, 64'h104);
    chk("bl_seq_pc", pc, 64'h144);
    drive(1'b1, 3'd7, 64'd0, 64'h9990);
    tick();
    chk("ret_pc", pc, 64'h104);
    chk("ret_ras_empty", {63'd0, ras_empty}, 64'd1);
    pc_exp = 64'h104;

    // Five nested BLs overflow a four-deep stack.
    for (int k = 0; k < 5; k++) begin
      links[k] = pc_exp + 64'd4;
      drive(1'b1, 3'd5, 64'h100, 64'd0);
      tick();
      pc_exp = pc_exp + 64'h100;
      chk($sformatf("nest_bl%0d_pc", k), pc, pc_exp);
      chk($sformatf("nest_bl%0d_link", k), link_addr, links[k]);
      chk($sformatf("nest_bl%0d_full", k), {63'd0, ras_full}, (k >= 3) ? 64'd1 : 64'd0);
    end
    chk("nest_link_valid", {63'd0, link_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'd7, 64'd0, 64'hDEAD0);
      tick();
      chk($sformatf("nest_ret%0d_pc", k), pc, (k < 4) ? links[4 - k] : 64'hDEAD0);
      chk($sformatf("nest_ret%0d_full", k), {63'd0, ras_full}, 64'd0);
      chk($sformatf("nest_ret%0d_empty", k), {63'd0, ras_empty}, (k >= 3) ? 64'd1 : 64'd0);
    end
    pc_exp = 64'hDEAD0;

    // Stalled BL: nothing moves, no pulse.
    stall = 1'b1;
    drive(1'b1, 3'd5, 64'h40, 64'd0);
    #1 chk("stall_taken", {63'd0, taken}, 64'd1);
    tick();
    chk("stall_pc", pc, pc_exp);
    chk("stall_link_valid", {63'd0, link_valid}, 64'd0);
    chk("stall_link_addr", link_addr, links[4]);
    chk("stall_ras_empty", {63'd0, ras_empty}, 64'd1);
    stall = 1'b0;

    // Wrap: branch to 0xFFFF_FFFF_FFFF_FFFC, then +4 wraps to 0.
    drive(1'b1, 3'd1, 64'd0 - pc_exp - 64'd4, 64'd0);
    tick(); chk("wrap_pre", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    tick(); chk("wrap_post", pc, 64'd0);

    // Async reset in the cycle after a BL.
    drive(1'b1, 3'd5, 64'h40, 64'd0);
    tick();
    chk("prerst_pc", pc, 64'h40);
    chk("prerst_link_valid", {63'd0, link_valid}, 64'd1);
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 64'd0);
    chk("arst_link_valid", {63'd0, link_valid}, 64'd0);
    chk("arst_link_addr", link_addr, 64'd0);
    chk("arst_ras_empty", {63'd0, ras_empty}, 64'd1);
    tick();
    rst = 1'b0;
    chk("arst_hold_pc", pc, 64'd0);
    tick();
    chk("arst_resume_pc", pc, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
